// File: rtl/dvs_event_fifo.sv
// Show-ahead event FIFO between the AER receiver and the RAVENS consumer.
// Events arriving while the FIFO is full are discarded and counted.
package dvs_ravens_pkg;
    localparam int DVS_X_ADDR_BITS   = 7;
    localparam int DVS_Y_ADDR_BITS   = 7;
    localparam int TIMESTAMP_US_BITS = 16;
endpackage

module dvs_event_fifo
    import dvs_ravens_pkg::*;
#(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int DROP_CNT_BITS = 16,
    localparam int EVENT_BITS    = 1 + DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + TIMESTAMP_US_BITS,
    localparam int CNT_BITS      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
    input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
    input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
    input  logic                         event_polarity,
    input  logic                         new_event,
    input  logic                         out_ready,
    input  logic                         clr_drop_count,
    output logic                         out_valid,
    output logic [EVENT_BITS-1:0]        out_event,
    output logic [CNT_BITS-1:0]          fill_level,
    output logic                         fifo_full,
    output logic [DROP_CNT_BITS-1:0]     drop_count
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam logic [DROP_CNT_BITS-1:0] DROP_MAX = {DROP_CNT_BITS{1'b1}};

    logic [EVENT_BITS-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]      r_wr_ptr;
    logic [PTR_BITS-1:0]      r_rd_ptr;
    logic [CNT_BITS-1:0]      r_count;
    logic                     r_valid;
    logic                     r_full;
    logic [DROP_CNT_BITS-1:0] r_drop_cnt;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [CNT_BITS-1:0]      w_count_nxt;
    logic [EVENT_BITS-1:0]    w_word;

    assign w_word = {event_polarity, event_y, event_x, event_timestamp};
    assign w_pop  = r_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the event.
    assign w_push = new_event & (~r_full | w_pop);
    assign w_drop = new_event & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_BITS'(1);
            2'b01:   w_count_nxt = r_count - CNT_BITS'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == CNT_BITS'(FIFO_DEPTH));
            // A clear that coincides with a drop keeps that drop visible.
            if (clr_drop_count)
                r_drop_cnt <= w_drop ? DROP_CNT_BITS'(1) : '0;
            else if (w_drop && r_drop_cnt != DROP_MAX)
                r_drop_cnt <= r_drop_cnt + DROP_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_pop && r_count == '0));
            assert (r_count <= CNT_BITS'(FIFO_DEPTH));
            assert (!(w_push && r_full && !w_pop));
        end
    end

    // Memory is not reset, so the head word is masked while empty.
    assign out_event  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign out_valid  = r_valid;
    assign fill_level = r_count;
    assign fifo_full  = r_full;
    assign drop_count = r_drop_cnt;
endmodule

// File: tb/tb_dvs_event_fifo.sv
// Directed bench for dvs_event_fifo; a scoreboard queue holds the words the
// FIFO should contain and every cycle the DUT state is compared with it.
module tb_dvs_event_fifo;
    import dvs_ravens_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DBITS  = 4;
    localparam int EBITS  = 1 + DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + TIMESTAMP_US_BITS;
    localparam int CBITS  = $clog2(DEPTH) + 1;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [DVS_X_ADDR_BITS-1:0]   event_x = '0;
    logic [DVS_Y_ADDR_BITS-1:0]   event_y = '0;
    logic [TIMESTAMP_US_BITS-1:0] event_timestamp = '0;
    logic                         event_polarity = 1'b0;
    logic                         new_event = 1'b0;
    logic                         out_ready = 1'b0;
    logic                         clr_drop_count = 1'b0;
    logic                         out_valid;
    logic [EBITS-1:0]             out_event;
    logic [CBITS-1:0]             fill_level;
    logic                         fifo_full;
    logic [DBITS-1:0]             drop_count;

    dvs_event_fifo #(.FIFO_DEPTH(DEPTH), .DROP_CNT_BITS(DBITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .event_x(event_x), .event_y(event_y),
        .event_timestamp(event_timestamp), .event_polarity(event_polarity),
        .new_event(new_event), .out_ready(out_ready), .clr_drop_count(clr_drop_count),
        .out_valid(out_valid), .out_event(out_event), .fill_level(fill_level),
        .fifo_full(fifo_full), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [EBITS-1:0] q[$];
    int               m_count = 0;
    logic [DBITS-1:0] m_drop = '0;
    logic [EBITS-1:0] last_pop = '0;

    function automatic logic [EBITS-1:0] pk(input logic pol, input logic [6:0] y,
                                            input logic [6:0] x, input logic [15:0] ts);
        return {pol, y, x, ts};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 64'(out_valid), 64'(m_count != 0));
        chk("fill_level", 64'(fill_level), 64'(m_count));
        chk("fifo_full", 64'(fifo_full), 64'(m_count == DEPTH));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    // One clock cycle: drive, check head word on pop, clock, update model.
    task automatic cyc(input logic nev, input logic pol, input logic [6:0] y, input logic [6:0] x,
                       input logic [15:0] ts, input logic rdy, input logic clr);
        logic mpop, mpush, mdrop;
        new_event = nev; event_polarity = pol; event_y = y; event_x = x;
        event_timestamp = ts; out_ready = rdy; clr_drop_count = clr;
        #1;
        check_state();
        mpop  = (m_count != 0) && rdy;
        mpush = nev && ((m_count < DEPTH) || mpop);
        mdrop = nev && (m_count == DEPTH) && !mpop;
        if (mpop) begin
            chk("out_event", 64'(out_event), 64'(q[0]));
            last_pop = q.pop_front();
            n_pop++;
        end
        if (mpush) q.push_back(pk(pol, y, x, ts));
        m_count = m_count + (mpush ? 1 : 0) - (mpop ? 1 : 0);
        if (clr) m_drop = mdrop ? DBITS'(1) : '0;
        else if (mdrop && m_drop != '1) m_drop = m_drop + DBITS'(1);
        @(posedge clk); #1;
        new_event = 1'b0; clr_drop_count = 1'b0;
    endtask

    task automatic ev(input int ts, input logic rdy);
        logic [15:0] t;
        t = 16'(ts);
        cyc(1'b1, t[0], ~t[6:0], t[6:0], t, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic clr);
        cyc(1'b0, 1'b0, 7'd0, 7'd0, 16'd0, rdy, clr);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) idle(1'b1, 1'b0);
    endtask

    initial begin
        int p0;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_state();
        chk("rst_out_event", 64'(out_event), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single event, show-ahead head word
        cyc(1'b1, 1'b1, 7'd9, 7'd5, 16'd100, 1'b0, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_word", 64'(out_event), 64'h4485_0064);
        idle(1'b0, 1'b0);
        chk("t1_hold", 64'(out_event), 64'h4485_0064);
        idle(1'b1, 1'b0);
        chk("t1_empty", 64'(out_valid), 64'd0);

        // 2: fill, overflow by two, drain in order
        for (int i = 0; i < 16; i++) ev(i, 1'b0);
        ev(16, 1'b0);
        ev(17, 1'b0);
        chk("t2_full", 64'(fifo_full), 64'd1);
        chk("t2_drops", 64'(drop_count), 64'd2);
        idle(1'b1, 1'b0);
        chk("t2_full_clr", 64'(fifo_full), 64'd0);
        drain(16);
        chk("t2_last", 64'(last_pop[15:0]), 64'd15);

        // 3: push into full FIFO while popping
        idle(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) ev(i + 32, 1'b0);
        ev(77, 1'b1);
        chk("t3_fill", 64'(fill_level), 64'd16);
        chk("t3_nodrop", 64'(drop_count), 64'd0);
        drain(17);
        chk("t3_last", 64'(last_pop[15:0]), 64'd77);

        // 4: streaming with pointer wrap
        p0 = n_pop;
        for (int i = 0; i < 40; i++) begin
            ev(200 + i, 1'b1);
            chk("t4_fill_le1", 64'(fill_level <= 1), 64'd1);
        end
        drain(2);
        chk("t4_count", 64'(n_pop - p0), 64'd40);
        chk("t4_last", 64'(last_pop[15:0]), 64'd239);

        // 5: drop counter saturation and clear
        for (int i = 0; i < 16; i++) ev(300 + i, 1'b0);
        for (int i = 0; i < 20; i++) ev(400 + i, 1'b0);
        chk("t5_sat", 64'(drop_count), 64'd15);
        cyc(1'b1, 1'b0, 7'd1, 7'd1, 16'd500, 1'b0, 1'b1);
        chk("t5_clr_drop", 64'(drop_count), 64'd1);
        idle(1'b0, 1'b1);
        chk("t5_clr", 64'(drop_count), 64'd0);
        drain(16);

        // 6: reset mid-stream
        for (int i = 0; i < 7; i++) ev(600 + i, 1'b0);
        chk("t6_fill7", 64'(fill_level), 64'd7);
        rst_n = 1'b0;
        #1;
        q.delete(); m_count = 0; m_drop = '0;
        check_state();
        chk("t6_out_event", 64'(out_event), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        p0 = n_pop;
        ev(700, 1'b0);
        drain(4);
        chk("t6_one_word", 64'(n_pop - p0), 64'd1);
        chk("t6_word", 64'(last_pop[15:0]), 64'd700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
